gshare_index_gen: RTL and testbench

//  Front end of the branch predictor, directly upstream of the 2-bit-counter pattern history table.
//  - Forms the table index as gshare: PC bits XOR global history register (GHR).
//  - Issues registered predict and resolve commands to the table.
//  - Queues the index of every in-flight prediction so its in-order resolution updates the same entry.
//  - Arbitrates the table's single command slot per cycle.

---
 rtl/gshare_index_gen_if.sv | 47 ++++
 rtl/gshare_index_gen.sv | 112 +++++++++++
 tb/tb_gshare_index_gen.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/gshare_index_gen_if.sv
// -----------------------------------------------------------------------------
// gshare_index_gen_if
// Purpose : bundles the branch-request, resolution and pattern-history-table
//           command signals of the gshare index generator.
// Signals :
//   br_valid/br_pc/br_ready       new branch asking for a prediction
//   res_valid/res_taken/res_ready oldest in-flight branch resolving
//   pht_en/pht_predict/pht_resolve/pht_incr/pht_decr/pht_index
//                                 registered command towards the table
//   outstanding                   number of predicted, unresolved branches
//   err_underflow                 sticky: resolution seen with nothing queued
// Modports: master = branch unit / testbench side, slave = index generator.
// -----------------------------------------------------------------------------
interface gshare_index_gen_if #(
  parameter int W_IND = 4,
  parameter int W_PC  = 32,
  parameter int DEPTH = 4
);
  localparam int W_OUT = $clog2(DEPTH) + 1;

  logic             br_valid;
  logic [W_PC-1:0]  br_pc;
  logic             br_ready;
  logic             res_valid;
  logic             res_taken;
  logic             res_ready;
  logic             pht_en;
  logic             pht_predict;
  logic             pht_resolve;
  logic             pht_incr;
  logic             pht_decr;
  logic [W_IND-1:0] pht_index;
  logic [W_OUT-1:0] outstanding;
  logic             err_underflow;

  modport master (
    output br_valid, br_pc, res_valid, res_taken,
    input  br_ready, res_ready, pht_en, pht_predict, pht_resolve,
           pht_incr, pht_decr, pht_index, outstanding, err_underflow
  );

  modport slave (
    input  br_valid, br_pc, res_valid, res_taken,
    output br_ready, res_ready, pht_en, pht_predict, pht_resolve,
           pht_incr, pht_decr, pht_index, outstanding, err_underflow
  );
endinterface

// File: rtl/gshare_index_gen.sv
// -----------------------------------------------------------------------------
// gshare_index_gen
// Purpose : front end of the branch predictor. Forms the pattern history table
//           index as PC[W_IND+1:2] XOR global history, issues registered
//           predict/resolve commands to the table, and remembers the index of
//           every in-flight prediction so that its in-order resolution updates
//           the same table entry.
// Ports   :
//   clk  in  rising-edge clock
//   rst  in  asynchronous active-high reset
//   bus  slave modport of gshare_index_gen_if (request, resolution, commands)
// -----------------------------------------------------------------------------
module gshare_index_gen #(
  parameter int W_IND = 4,
  parameter int W_PC  = 32,
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  gshare_index_gen_if.slave    bus
);
  localparam int              W_PTR = $clog2(DEPTH);
  localparam int              W_OUT = W_PTR + 1;
  localparam logic [W_OUT-1:0] FULL = W_OUT'(DEPTH);

  logic [W_IND-1:0] r_ghr;
  logic [W_IND-1:0] r_queue [DEPTH];
  logic [W_PTR-1:0] r_wr_ptr;
  logic [W_PTR-1:0] r_rd_ptr;
  logic [W_OUT-1:0] r_count;
  logic             r_pht_en;
  logic             r_pht_predict;
  logic             r_pht_resolve;
  logic             r_pht_incr;
  logic             r_pht_decr;
  logic [W_IND-1:0] r_pht_index;
  logic             r_err_underflow;

  logic             w_empty;
  logic             w_br_ready;
  logic             w_res_acc;
  logic             w_br_acc;
  logic [W_IND-1:0] w_idx;
  logic [W_IND-1:0] w_head;

  assign w_empty    = (r_count == '0);
  // A pending resolution blocks new predictions in the same cycle, so push
  // and pop are mutually exclusive and only one command can be issued.
  assign w_br_ready = (r_count != FULL) & ~bus.res_valid;
  assign w_res_acc  = bus.res_valid & ~w_empty;
  assign w_br_acc   = bus.br_valid & w_br_ready;
  // History is non-speculative: the index uses the GHR as of acceptance.
  assign w_idx      = bus.br_pc[W_IND+1:2] ^ r_ghr;
  assign w_head     = r_queue[r_rd_ptr];

  // Index storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (w_br_acc) begin
      r_queue[r_wr_ptr] <= w_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ghr           <= '0;
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_count         <= '0;
      r_pht_en        <= 1'b0;
      r_pht_predict   <= 1'b0;
      r_pht_resolve   <= 1'b0;
      r_pht_incr      <= 1'b0;
      r_pht_decr      <= 1'b0;
      r_pht_index     <= '0;
      r_err_underflow <= 1'b0;
    end else begin
      // Command strobes are single-cycle pulses following an acceptance.
      r_pht_en      <= w_res_acc | w_br_acc;
      r_pht_predict <= w_br_acc;
      r_pht_resolve <= w_res_acc;
      r_pht_incr    <= w_res_acc & bus.res_taken;
      r_pht_decr    <= w_res_acc & ~bus.res_taken;

      if (w_res_acc) begin
        // Pointers are W_PTR wide, so they wrap modulo DEPTH on their own.
        r_rd_ptr    <= r_rd_ptr + W_PTR'(1);
        r_count     <= r_count - W_OUT'(1);
        r_ghr       <= {r_ghr[W_IND-2:0], bus.res_taken};
        r_pht_index <= w_head;
      end else if (w_br_acc) begin
        r_wr_ptr    <= r_wr_ptr + W_PTR'(1);
        r_count     <= r_count + W_OUT'(1);
        r_pht_index <= w_idx;
      end

      if (bus.res_valid && w_empty) begin
        r_err_underflow <= 1'b1;
      end
    end
  end

  assign bus.br_ready      = w_br_ready;
  assign bus.res_ready     = ~w_empty;
  assign bus.pht_en        = r_pht_en;
  assign bus.pht_predict   = r_pht_predict;
  assign bus.pht_resolve   = r_pht_resolve;
  assign bus.pht_incr      = r_pht_incr;
  assign bus.pht_decr      = r_pht_decr;
  assign bus.pht_index     = r_pht_index;
  assign bus.outstanding   = r_count;
  assign bus.err_underflow = r_err_underflow;
endmodule

// File: tb/tb_gshare_index_gen.sv
// -----------------------------------------------------------------------------
// tb_gshare_index_gen
// Directed vectors for gshare_index_gen (W_IND=4, DEPTH=4) with hand-computed
// expected table indices, strobes, occupancy and error flag.
// -----------------------------------------------------------------------------
module tb_gshare_index_gen;
  logic clk;
  logic rst;
  int   n_vec;
  int   n_miss;

  gshare_index_gen_if #(.W_IND(4), .W_PC(32), .DEPTH(4)) bus ();

  gshare_index_gen #(.W_IND(4), .W_PC(32), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge, where registered outputs are stable.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    tick();
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    rst = 1'b1;
    bus.br_valid  = 1'b0;
    bus.br_pc     = '0;
    bus.res_valid = 1'b0;
    bus.res_taken = 1'b0;

    // T1: reset state
    #3;
    check("t1_pht_en",      bus.pht_en, 0);
    check("t1_pht_predict", bus.pht_predict, 0);
    check("t1_pht_resolve", bus.pht_resolve, 0);
    check("t1_pht_incr",    bus.pht_incr, 0);
    check("t1_pht_decr",    bus.pht_decr, 0);
    check("t1_pht_index",   bus.pht_index, 0);
    check("t1_outstanding", bus.outstanding, 0);
    check("t1_br_ready",    bus.br_ready, 1);
    check("t1_res_ready",   bus.res_ready, 0);
    check("t1_err",         bus.err_underflow, 0);
    $display("T1 reset applied");
    tick();
    rst = 1'b0;
    tick();

    // T2: predict pc 0x34 with GHR=0 -> index 0xD
    bus.br_valid = 1'b1; bus.br_pc = 32'h34;
    #1 check("t2_br_ready", bus.br_ready, 1);
    tick();
    bus.br_valid = 1'b0;
    check("t2_pht_en",      bus.pht_en, 1);
    check("t2_pht_predict", bus.pht_predict, 1);
    check("t2_pht_resolve", bus.pht_resolve, 0);
    check("t2_pht_index",   bus.pht_index, 4'hD);
    check("t2_outstanding", bus.outstanding, 1);
    $display("T2 predict pc=0x34 idx=0x%0h", bus.pht_index);
    tick();
    check("t2_idle_en",    bus.pht_en, 0);
    check("t2_idle_pred",  bus.pht_predict, 0);
    check("t2_idle_hold",  bus.pht_index, 4'hD);

    // T3: resolve taken -> index 0xD, GHR=1; then pc 0x34 -> 0xC
    bus.res_valid = 1'b1; bus.res_taken = 1'b1;
    #1;
    check("t3_res_ready", bus.res_ready, 1);
    check("t3_br_ready",  bus.br_ready, 0);
    tick();
    bus.res_valid = 1'b0;
    check("t3_pht_resolve", bus.pht_resolve, 1);
    check("t3_pht_predict", bus.pht_predict, 0);
    check("t3_pht_incr",    bus.pht_incr, 1);
    check("t3_pht_decr",    bus.pht_decr, 0);
    check("t3_pht_index",   bus.pht_index, 4'hD);
    check("t3_outstanding", bus.outstanding, 0);
    $display("T3 resolve taken idx=0x%0h", bus.pht_index);
    bus.br_valid = 1'b1; bus.br_pc = 32'h34;
    tick();
    bus.br_valid = 1'b0;
    check("t3_pred2",  bus.pht_predict, 1);
    check("t3_index2", bus.pht_index, 4'hC);
    $display("T3 predict pc=0x34 idx=0x%0h", bus.pht_index);
    do_reset();

    // T4: fill queue, overflow attempt, drain T,N,T,N
    bus.br_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.br_pc = 32'(i * 4);
      tick();
      check("t4_fill_pred", bus.pht_predict, 1);
      check("t4_fill_idx",  bus.pht_index, 32'(i));
      $display("T4 predict pc=0x%0h idx=0x%0h", i * 4, bus.pht_index);
    end
    bus.br_pc = 32'h10;
    #1;
    check("t4_full_ready", bus.br_ready, 0);
    check("t4_full_out",   bus.outstanding, 4);
    tick();
    bus.br_valid = 1'b0;
    check("t4_ovf_en",  bus.pht_en, 0);
    check("t4_ovf_out", bus.outstanding, 4);
    $display("T4 fifth request ignored");
    bus.res_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.res_taken = ((i % 2) == 0);
      tick();
      check("t4_res",  bus.pht_resolve, 1);
      check("t4_idx",  bus.pht_index, 32'(i));
      check("t4_incr", bus.pht_incr, ((i % 2) == 0) ? 1 : 0);
      check("t4_decr", bus.pht_decr, ((i % 2) == 0) ? 0 : 1);
      $display("T4 resolve taken=%0d idx=0x%0h", bus.res_taken, bus.pht_index);
    end
    bus.res_valid = 1'b0;
    check("t4_drained", bus.outstanding, 0);
    // GHR should now be 0xA: pc 0 maps to index 0xA
    bus.br_valid = 1'b1; bus.br_pc = 32'h0;
    tick();
    bus.br_valid = 1'b0;
    check("t4_ghr_idx", bus.pht_index, 4'hA);
    bus.res_valid = 1'b1; bus.res_taken = 1'b0;
    tick();
    bus.res_valid = 1'b0;
    check("t4_ghr_res_idx", bus.pht_index, 4'hA);
    check("t4_ghr_res_decr", bus.pht_decr, 1);
    $display("T4 ghr probe idx=0xa resolved not-taken");

    // T5: GHR=0x4. Two predicts, then simultaneous request and resolve.
    bus.br_valid = 1'b1; bus.br_pc = 32'h0;
    tick();
    check("t5_idx_a", bus.pht_index, 4'h4);
    bus.br_pc = 32'h4;
    tick();
    check("t5_idx_b", bus.pht_index, 4'h5);
    bus.br_pc = 32'h8;
    bus.res_valid = 1'b1; bus.res_taken = 1'b1;
    #1;
    check("t5_br_ready",  bus.br_ready, 0);
    check("t5_res_ready", bus.res_ready, 1);
    check("t5_out2",      bus.outstanding, 2);
    tick();
    bus.res_valid = 1'b0;
    check("t5_res_only",  bus.pht_resolve, 1);
    check("t5_no_pred",   bus.pht_predict, 0);
    check("t5_res_idx",   bus.pht_index, 4'h4);
    check("t5_out1",      bus.outstanding, 1);
    $display("T5 collision: resolve idx=0x%0h", bus.pht_index);
    tick();
    bus.br_valid = 1'b0;
    check("t5_late_pred", bus.pht_predict, 1);
    check("t5_late_idx",  bus.pht_index, 4'hB);
    check("t5_out2b",     bus.outstanding, 2);
    $display("T5 deferred predict idx=0x%0h", bus.pht_index);
    bus.res_valid = 1'b1; bus.res_taken = 1'b0;
    tick();
    check("t5_drain1", bus.pht_index, 4'h5);
    tick();
    bus.res_valid = 1'b0;
    check("t5_drain2", bus.pht_index, 4'hB);
    check("t5_empty",  bus.outstanding, 0);

    // T6a: underflow with GHR=0x4
    bus.res_valid = 1'b1; bus.res_taken = 1'b1;
    #1 check("t6_res_ready", bus.res_ready, 0);
    tick();
    bus.res_valid = 1'b0;
    check("t6_uf_en",  bus.pht_en, 0);
    check("t6_uf_err", bus.err_underflow, 1);
    check("t6_uf_out", bus.outstanding, 0);
    $display("T6a underflow flagged");
    tick();
    check("t6_uf_sticky", bus.err_underflow, 1);
    bus.br_valid = 1'b1; bus.br_pc = 32'h0;
    tick();
    check("t6_ghr_kept", bus.pht_index, 4'h4);

    // T6b: reset with three outstanding
    bus.br_pc = 32'h4;
    tick();
    bus.br_pc = 32'h8;
    tick();
    check("t6_out3", bus.outstanding, 3);
    bus.br_pc = 32'hC;
    rst = 1'b1;
    #1;
    check("t6_rst_out",  bus.outstanding, 0);
    check("t6_rst_err",  bus.err_underflow, 0);
    check("t6_rst_en",   bus.pht_en, 0);
    check("t6_rst_pred", bus.pht_predict, 0);
    bus.br_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("t6_post_en",  bus.pht_en, 0);
    check("t6_post_out", bus.outstanding, 0);
    bus.br_valid = 1'b1; bus.br_pc = 32'h34;
    tick();
    bus.br_valid = 1'b0;
    check("t6_post_idx", bus.pht_index, 4'hD);
    $display("T6b reset mid-operation, ghr cleared idx=0x%0h", bus.pht_index);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
